// File: rtl/regfile_burst_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_burst_arbiter_if
//  Purpose  : Bundles the two requester channels (A, B) and the status
//             outputs of regfile_burst_arbiter into one interface.
//  Ports    : a_*/b_* : req/we/addr/len/wdata (requester -> arbiter)
//                       gnt/ack/rvalid/rdata  (arbiter -> requester)
//             sel, cnt, busy : owner select, beat index, burst in progress
//  Modports : master = requester side, slave = arbiter side
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_burst_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int LW = 3
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [LW-1:0] a_len;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_ack;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [LW-1:0] b_len;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_ack;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  logic          sel;
  logic [LW-1:0] cnt;
  logic          busy;

  modport master (
    output a_req, a_we, a_addr, a_len, a_wdata,
    output b_req, b_we, b_addr, b_len, b_wdata,
    input  a_gnt, a_ack, a_rvalid, a_rdata,
    input  b_gnt, b_ack, b_rvalid, b_rdata,
    input  sel, cnt, busy
  );

  modport slave (
    input  a_req, a_we, a_addr, a_len, a_wdata,
    input  b_req, b_we, b_addr, b_len, b_wdata,
    output a_gnt, a_ack, a_rvalid, a_rdata,
    output b_gnt, b_ack, b_rvalid, b_rdata,
    output sel, cnt, busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_burst_arbiter
//  Purpose  : 2**AW x DW register array shared by requesters A and B under
//             round-robin arbitration. Each grant runs a burst of len+1
//             read or write beats at consecutive (wrapping) addresses.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous reset, active-high
//             bus  - regfile_burst_arbiter_if.slave (requester channels,
//                    sel/cnt/busy status)
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_burst_arbiter #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int LW = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_burst_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_sel;      // 1 = A owns the array
  logic          r_we;
  logic          r_ptr;      // 1 = A wins a tie next time
  logic [AW-1:0] r_base;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_cnt;
  logic          r_a_rvalid;
  logic          r_b_rvalid;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;
  logic [DW-1:0] r_mem [0:(2**AW)-1];

  logic          w_win;
  logic          w_win_a;
  logic          w_first;
  logic          w_last;
  logic          w_wr;
  logic [AW-1:0] w_addr;

  // Address arithmetic is AW bits wide, so base+cnt wraps naturally.
  assign w_addr  = r_base + AW'(r_cnt);
  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == r_len);
  assign w_wr    = (r_state == S_BURST) && r_we;

  // --------------------------------------------------------------------------
  // Next-state and beat outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_win       = 1'b0;
    w_win_a     = 1'b0;
    bus.a_gnt   = 1'b0;
    bus.a_ack   = 1'b0;
    bus.b_gnt   = 1'b0;
    bus.b_ack   = 1'b0;
    bus.busy    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          w_win       = 1'b1;
          // A wins alone, or on a tie when the pointer favours it.
          w_win_a     = bus.a_req && (!bus.b_req || r_ptr);
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        bus.busy  = 1'b1;
        bus.a_ack = r_sel;
        bus.b_ack = !r_sel;
        bus.a_gnt = r_sel && w_first;
        bus.b_gnt = !r_sel && w_first;
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Burst context, beat counter and registered read returns
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel      <= 1'b0;
      r_we       <= 1'b0;
      r_ptr      <= 1'b1;
      r_base     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      if (w_win) begin
        r_sel  <= w_win_a;
        r_we   <= w_win_a ? bus.a_we   : bus.b_we;
        r_base <= w_win_a ? bus.a_addr : bus.b_addr;
        r_len  <= w_win_a ? bus.a_len  : bus.b_len;
        r_cnt  <= '0;
        r_ptr  <= !w_win_a;
      end
      if (r_state == S_BURST) begin
        r_cnt <= w_last ? '0 : r_cnt + LW'(1);
        // rdata of the non-owner is left untouched so it holds.
        if (!r_we) begin
          if (r_sel) begin
            r_a_rvalid <= 1'b1;
            r_a_rdata  <= r_mem[w_addr];
          end else begin
            r_b_rvalid <= 1'b1;
            r_b_rdata  <= r_mem[w_addr];
          end
        end
      end
    end
  end

  // Storage is not reset; reset forces IDLE, which blocks further writes.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_addr] <= r_sel ? bus.a_wdata : bus.b_wdata;
    end
  end

  assign bus.sel      = r_sel;
  assign bus.cnt      = r_cnt;
  assign bus.a_rvalid = r_a_rvalid;
  assign bus.a_rdata  = r_a_rdata;
  assign bus.b_rvalid = r_b_rvalid;
  assign bus.b_rdata  = r_b_rdata;

endmodule
`default_nettype wire

// File: tb/tb_regfile_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_burst_arbiter
//  Purpose  : Self-checking bench for regfile_burst_arbiter: a cycle table
//             for an A write/read burst pair, then hand sequences for
//             round-robin ties, B-only traffic, a full-length wrapping
//             burst, reset mid-burst and req dropped mid-burst.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_burst_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  regfile_burst_arbiter_if #(.DW(8), .AW(4), .LW(3)) ifc ();

  regfile_burst_arbiter #(.DW(8), .AW(4), .LW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // flags = {a_gnt, a_ack, a_rvalid, b_gnt, b_ack, b_rvalid, sel, busy}
  typedef struct packed {
    logic       a_req;
    logic       a_we;
    logic [3:0] a_addr;
    logic [2:0] a_len;
    logic [7:0] a_wdata;
    logic [7:0] flags;
    logic [2:0] cnt;
    logic [7:0] ard;
    logic [7:0] brd;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ifc.a_req = 1'b0; ifc.a_we = 1'b0; ifc.a_addr = '0; ifc.a_len = '0; ifc.a_wdata = '0;
    ifc.b_req = 1'b0; ifc.b_we = 1'b0; ifc.b_addr = '0; ifc.b_len = '0; ifc.b_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input bit is_a, input logic v);
    if (is_a) ifc.a_req = v; else ifc.b_req = v;
  endtask

  task automatic set_wdata(input bit is_a, input logic [7:0] d);
    if (is_a) ifc.a_wdata = d; else ifc.b_wdata = d;
  endtask

  // Called at a negedge with the DUT idle. Byte i of data is the write data
  // (or expected read data) of beat i. req is dropped in beat drop_at.
  task automatic burst(input bit is_a, input bit we, input logic [3:0] addr,
                       input logic [2:0] len, input logic [63:0] data, input int drop_at);
    int  n;
    bit  seen;
    n = int'(len) + 1;
    seen = 1'b0;
    if (is_a) begin
      ifc.b_req = 1'b0; ifc.a_we = we; ifc.a_addr = addr; ifc.a_len = len;
    end else begin
      ifc.a_req = 1'b0; ifc.b_we = we; ifc.b_addr = addr; ifc.b_len = len;
    end
    set_req(is_a, 1'b1);
    set_wdata(is_a, data[7:0]);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if ((is_a ? ifc.a_gnt : ifc.b_gnt) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check($sformatf("burst a=%0d addr=%0d grant_seen", is_a, addr), 32'(seen), 32'd1);
    if (!seen) return;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("burst a=%0d beat%0d gnt", is_a, i), 32'(is_a ? ifc.a_gnt : ifc.b_gnt), 32'(i == 0));
      check($sformatf("burst a=%0d beat%0d ack", is_a, i), 32'(is_a ? ifc.a_ack : ifc.b_ack), 32'd1);
      check($sformatf("burst a=%0d beat%0d other_ack", is_a, i), 32'(is_a ? ifc.b_ack : ifc.a_ack), 32'd0);
      check($sformatf("burst a=%0d beat%0d cnt", is_a, i), 32'(ifc.cnt), 32'(i));
      check($sformatf("burst a=%0d beat%0d sel", is_a, i), 32'(ifc.sel), 32'(is_a));
      check($sformatf("burst a=%0d beat%0d rvalid", is_a, i),
            32'(is_a ? ifc.a_rvalid : ifc.b_rvalid), 32'(!we && i > 0));
      if (!we && i > 0)
        check($sformatf("burst a=%0d beat%0d rdata", is_a, i),
              32'(is_a ? ifc.a_rdata : ifc.b_rdata), 32'(data[8*(i-1) +: 8]));
      set_wdata(is_a, data[8*i +: 8]);
      if (i == drop_at) set_req(is_a, 1'b0);
    end
    @(negedge clk);
    set_req(is_a, 1'b0);
    check($sformatf("burst a=%0d end busy", is_a), 32'(ifc.busy), 32'd0);
    check($sformatf("burst a=%0d end rvalid", is_a), 32'(is_a ? ifc.a_rvalid : ifc.b_rvalid), 32'(!we));
    if (!we)
      check($sformatf("burst a=%0d end rdata", is_a),
            32'(is_a ? ifc.a_rdata : ifc.b_rdata), 32'(data[8*(n-1) +: 8]));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();

    // ---- A write 14..1 then read back, cycle by cycle ----
    tbl[0]  = '{1'b1, 1'b1, 4'd14, 3'd3, 8'h01, 8'b00000000, 3'd0, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 4'd14, 3'd3, 8'h01, 8'b11000011, 3'd0, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 4'd14, 3'd3, 8'h02, 8'b01000011, 3'd1, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 4'd14, 3'd3, 8'h03, 8'b01000011, 3'd2, 8'h00, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 4'd14, 3'd3, 8'h04, 8'b01000011, 3'd3, 8'h00, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 4'd14, 3'd3, 8'h00, 8'b00000010, 3'd0, 8'h00, 8'h00};
    tbl[6]  = '{1'b0, 1'b0, 4'd14, 3'd3, 8'h00, 8'b11000011, 3'd0, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 4'd14, 3'd3, 8'h00, 8'b01100011, 3'd1, 8'h01, 8'h00};
    tbl[8]  = '{1'b0, 1'b0, 4'd14, 3'd3, 8'h00, 8'b01100011, 3'd2, 8'h02, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 4'd14, 3'd3, 8'h00, 8'b01100011, 3'd3, 8'h03, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 4'd14, 3'd3, 8'h00, 8'b00100010, 3'd0, 8'h04, 8'h00};
    tbl[11] = '{1'b0, 1'b0, 4'd14, 3'd3, 8'h00, 8'b00000010, 3'd0, 8'h04, 8'h00};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("t1[%0d] flags", i),
            32'({ifc.a_gnt, ifc.a_ack, ifc.a_rvalid, ifc.b_gnt, ifc.b_ack, ifc.b_rvalid, ifc.sel, ifc.busy}),
            32'(tbl[i].flags));
      check($sformatf("t1[%0d] cnt", i), 32'(ifc.cnt), 32'(tbl[i].cnt));
      check($sformatf("t1[%0d] a_rdata", i), 32'(ifc.a_rdata), 32'(tbl[i].ard));
      check($sformatf("t1[%0d] b_rdata", i), 32'(ifc.b_rdata), 32'(tbl[i].brd));
      ifc.a_req   = tbl[i].a_req;
      ifc.a_we    = tbl[i].a_we;
      ifc.a_addr  = tbl[i].a_addr;
      ifc.a_len   = tbl[i].a_len;
      ifc.a_wdata = tbl[i].a_wdata;
    end
    // Array now: [14]=01 [15]=02 [0]=03 [1]=04

    // ---- Both requesting, len=0: A,B,A,B with one idle cycle between ----
    do_reset();
    ifc.a_req = 1'b1; ifc.a_we = 1'b0; ifc.a_addr = 4'd0; ifc.a_len = 3'd0;
    ifc.b_req = 1'b1; ifc.b_we = 1'b0; ifc.b_addr = 4'd1; ifc.b_len = 3'd0;
    for (int k = 0; k < 9; k++) begin
      bit ab, bb, arv, brv;
      if (k > 0) @(negedge clk);
      ab  = (k % 4 == 1);
      bb  = (k % 4 == 3);
      arv = (k % 4 == 2);
      brv = (k > 0) && (k % 4 == 0);
      check($sformatf("rr[%0d] a_gnt", k), 32'(ifc.a_gnt), 32'(ab));
      check($sformatf("rr[%0d] b_gnt", k), 32'(ifc.b_gnt), 32'(bb));
      check($sformatf("rr[%0d] a_ack", k), 32'(ifc.a_ack), 32'(ab));
      check($sformatf("rr[%0d] b_ack", k), 32'(ifc.b_ack), 32'(bb));
      check($sformatf("rr[%0d] a_rvalid", k), 32'(ifc.a_rvalid), 32'(arv));
      check($sformatf("rr[%0d] b_rvalid", k), 32'(ifc.b_rvalid), 32'(brv));
      if (arv) check($sformatf("rr[%0d] a_rdata", k), 32'(ifc.a_rdata), 32'h03);
      if (brv) check($sformatf("rr[%0d] b_rdata", k), 32'(ifc.b_rdata), 32'h04);
    end
    ifc.a_req = 1'b0;
    ifc.b_req = 1'b0;

    // ---- Only B, len=1: 2 beats + 1 idle, repeated ----
    do_reset();
    ifc.b_req = 1'b1; ifc.b_we = 1'b0; ifc.b_addr = 4'd2; ifc.b_len = 3'd1;
    for (int k = 0; k < 9; k++) begin
      int ph;
      if (k > 0) @(negedge clk);
      ph = k % 3;
      check($sformatf("bonly[%0d] b_gnt", k), 32'(ifc.b_gnt), 32'(ph == 1));
      check($sformatf("bonly[%0d] b_ack", k), 32'(ifc.b_ack), 32'(ph != 0));
      check($sformatf("bonly[%0d] cnt", k), 32'(ifc.cnt), 32'(ph == 2));
      check($sformatf("bonly[%0d] busy", k), 32'(ifc.busy), 32'(ph != 0));
      check($sformatf("bonly[%0d] sel", k), 32'(ifc.sel), 32'd0);
      check($sformatf("bonly[%0d] a_gnt", k), 32'(ifc.a_gnt), 32'd0);
    end
    ifc.b_req = 1'b0;

    // ---- B full-length wrapping burst at 9, then readback ----
    do_reset();
    burst(1'b0, 1'b1, 4'd9, 3'd7, 64'h1716151413121110, 0);
    burst(1'b0, 1'b0, 4'd9, 3'd7, 64'h1716151413121110, 0);

    // ---- Reset during beat 2 of an A write at 4 ----
    burst(1'b1, 1'b1, 4'd4, 3'd3, 64'h00000000A3A2A1A0, 0);
    ifc.a_req = 1'b1; ifc.a_we = 1'b1; ifc.a_addr = 4'd4; ifc.a_len = 3'd3; ifc.a_wdata = 8'hC0;
    @(negedge clk);
    check("rstmid beat0 a_gnt", 32'(ifc.a_gnt), 32'd1);
    ifc.a_req = 1'b0;
    @(negedge clk);
    ifc.a_wdata = 8'hC1;
    @(negedge clk);
    check("rstmid beat2 cnt", 32'(ifc.cnt), 32'd2);
    ifc.a_wdata = 8'hC2;
    #1 rst = 1'b1;
    #1;
    check("rstmid outputs",
          32'({ifc.a_gnt, ifc.a_ack, ifc.a_rvalid, ifc.b_gnt, ifc.b_ack, ifc.b_rvalid, ifc.sel, ifc.busy}),
          32'd0);
    check("rstmid cnt", 32'(ifc.cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // Readback, with a_req dropped in beat 1: no second grant may follow.
    burst(1'b1, 1'b0, 4'd4, 3'd3, 64'h00000000A3A2C1C0, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("drop idle[%0d] a_gnt", k), 32'(ifc.a_gnt), 32'd0);
      check($sformatf("drop idle[%0d] busy", k), 32'(ifc.busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_burst_arbiter.md
Name: regfile_burst_arbiter

Overview:
- Owns a 16x8 register array and shares it between two requesters, A and B, using round-robin arbitration.
- Each grant runs a burst of 1..8 read or write beats at consecutive addresses, with wrap-around.
- Provides the owner-select, beat counter and busy status that sequence the shared array.
- Sits between two client engines and the storage array in the procedural datapath.

Parameters:
- DW, 8, data width.
- AW, 4, address width; array depth = 2**AW.
- LW, 3, burst-length field width; max burst = 2**LW beats.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- a_req  input  1  requester A wants a burst; hold high until a_gnt.
- a_we  input  1  A burst is write (1) or read (0).
- a_addr  input  AW  A burst base address.
- a_len  input  LW  A burst beats minus 1.
- a_wdata  input  DW  A write data, one word per beat.
- a_gnt  output  1  one-cycle pulse, A burst accepted (coincides with first beat).
- a_ack  output  1  high during each A beat.
- a_rvalid  output  1  A read data valid.
- a_rdata  output  DW  A read data.
- b_req, b_we, b_addr, b_len, b_wdata, b_gnt, b_ack, b_rvalid, b_rdata: same as A, for requester B.
- sel  output  1  current owner: 1=A, 0=B.
- cnt  output  LW  current beat index.
- busy  output  1  burst in progress.

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0. Priority pointer favours A. Array contents not cleared.
- States: IDLE, BURST.
- IDLE, at the rising edge:
  - Only one requester has req high: that requester wins.
  - Both have req high: the one not served last wins.
  - On a win: latch we, addr, len from the winner's inputs in that cycle; set sel; cnt=0; go to BURST; update the pointer.
- BURST, every cycle is one beat:
  - Owner's gnt is high on beat 0 only; owner's ack is high on every beat; busy=1.
  - Beat address = (base + cnt) mod 2**AW, so address 15 wraps to 0.
  - Write beat: owner's wdata is written at the edge ending the beat.
  - Read beat: rdata/rvalid are registered and appear in the cycle after the beat (1-cycle latency). rvalid goes only to the owner. The other requester's rdata holds its last value.
  - cnt increments each beat.
  - When cnt==len: go to IDLE at the next edge, cnt returns to 0, busy drops.
- Between bursts: at least one IDLE cycle. Back-to-back grants are therefore separated by exactly one cycle, even with both req high.
- req inputs are ignored during BURST. Changes to addr/len/we after grant have no effect. Deasserting req mid-burst does not abort the burst.
- Reset mid-burst: burst aborted; beats not yet completed perform no write; completed writes persist.
- The non-owner's gnt, ack and rvalid are never high.

Test Plan:
- Reset; A write, addr=14, len=3, wdata 0x01,0x02,0x03,0x04 on successive acks -> a_gnt for 1 cycle, a_ack for 4 cycles, busy for 4 cycles, sel=1. Then A read, addr=14, len=3 -> a_rvalid for 4 cycles, each one cycle after its ack, data 0x01,0x02,0x03,0x04 (addresses 14,15,0,1).
- Both req held high continuously after reset, len=0 each -> grants A,B,A,B with one idle cycle between; b_* outputs silent during A beats and vice versa.
- Only B requesting repeatedly, len=1 -> each burst is 2 beats + 1 idle cycle; sel=0; a_gnt never asserts.
- B write, addr=9, len=7, data 0x10..0x17 -> 8 beats, cnt 0..7, addresses 9..15,0. Readback from addr 9 returns 0x10..0x17.
- A write, addr=4, len=3; rst pulsed during beat 2 -> immediately all outputs 0, state IDLE. Readback: addr 4=first word, addr 5=second word; addrs 6,7 unchanged from their prior contents.
- a_req deasserted during beat 1 of a len=3 read -> all 4 beats and 4 rvalids still occur; no second grant.
